// File: rtl/ra_builder_pkg.sv
// Shared definitions for the Region Array builder: control-word layout,
// the empty-list pointer marker, list size decoding and the FSM state type.
package ra_builder_pkg;

  localparam int NUM_LISTS = 5;
  // Widest per-tile offset or stride is 5 x 128 B = 640 B, which fits in 10 bits.
  localparam int OFF_W = 10;

  localparam int CTRL_LAST   = 31;
  localparam int CTRL_ZCLEAR = 30;
  localparam int CTRL_FLUSH  = 28;
  localparam int TILEY_MSB   = 13;
  localparam int TILEY_LSB   = 8;
  localparam int TILEX_MSB   = 7;
  localparam int TILEX_LSB   = 2;

  localparam logic [31:0] EMPTY_PTR = 32'h8000_0000;

  typedef enum logic [3:0] {
    IDLE,
    SETUP,
    W_CTRL,
    W_O,
    W_OM,
    W_T,
    W_TM,
    W_PT,
    NEXT,
    DONE
  } ra_state_t;

  // Bytes reserved per tile for one list type, from its 2-bit size code.
  function automatic logic [7:0] list_bytes(input logic [1:0] code);
    case (code)
      2'd1:    return 8'd32;
      2'd2:    return 8'd64;
      2'd3:    return 8'd128;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/ra_builder_ol_layout.sv
// Per-tile object list layout: turns the latched allocation control word into
// a byte offset and an empty flag for each list type, plus the per-tile stride.
module ra_ol_layout
  import ra_builder_pkg::*;
(
  input  logic [31:0]                      alloc,
  output logic [NUM_LISTS-1:0][OFF_W-1:0]  offset,
  output logic [NUM_LISTS-1:0]             empty,
  output logic [OFF_W-1:0]                 stride
);

  logic [OFF_W-1:0] acc;
  logic [1:0]       code;
  logic             unused_alloc;

  // Size codes sit at a 4-bit pitch in order o, om, t, tm, pt; disabled
  // types take no space, so later offsets only accumulate enabled blocks.
  always_comb begin
    acc    = '0;
    code   = '0;
    offset = '0;
    empty  = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      code      = alloc[4*i +: 2];
      offset[i] = acc;
      empty[i]  = (code == 2'd0);
      acc       = acc + OFF_W'(list_bytes(code));
    end
    stride = acc;
  end

  assign unused_alloc = ^{alloc[31:18], alloc[15:14], alloc[11:10], alloc[7:6], alloc[3:2]};

endmodule

// File: rtl/ra_builder.sv
// Region Array builder: walks the tile grid in row-major order and writes one
// control word plus five (v2) or four (v1) list pointers per tile into VRAM.
module ra_builder
  import ra_builder_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ra_gen_trig,
  input  logic [31:0]       FPU_PARAM_CFG,
  input  logic [31:0]       REGION_BASE,
  input  logic [31:0]       TA_OL_BASE,
  input  logic [31:0]       TA_ALLOC_CTRL,
  input  logic [31:0]       TA_GLOB_TILE_CLIP,
  input  logic              ra_zclear,
  input  logic              ra_flush,
  output logic              ra_vram_wr,
  output logic [ADDR_W-1:0] ra_vram_addr,
  output logic [31:0]       ra_vram_dout,
  input  logic              ra_vram_wait,
  output logic              ra_busy,
  output logic              ra_done
);

  ra_state_t state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] tile_ol;
  logic [5:0]        tx;
  logic [3:0]        ty;

  // Configuration captured at SETUP and held for the whole run.
  logic              cfg_v2;
  logic [31:0]       cfg_alloc;
  logic [5:0]        cfg_xmax;
  logic [3:0]        cfg_ymax;
  logic              cfg_zclear;
  logic              cfg_flush;

  logic [NUM_LISTS-1:0][OFF_W-1:0] offset;
  logic [NUM_LISTS-1:0]            empty;
  logic [OFF_W-1:0]                stride;

  logic        last;
  logic [31:0] ctrl_word;
  logic        unused_cfg;

  ra_ol_layout u_layout (
    .alloc  (cfg_alloc),
    .offset (offset),
    .empty  (empty),
    .stride (stride)
  );

  // Pointer for one list type: the empty marker, or the tile's list base plus offset.
  function automatic logic [31:0] ptr_word(input logic is_empty,
                                           input logic [ADDR_W-1:0] base,
                                           input logic [OFF_W-1:0] off);
    logic [ADDR_W-1:0] p;
    p = base + ADDR_W'(off);
    return is_empty ? EMPTY_PTR : 32'(p);
  endfunction

  assign last = (tx == cfg_xmax) && (ty == cfg_ymax);

  // Control word assembled from the current tile position and latched flags.
  always_comb begin
    ctrl_word                        = '0;
    ctrl_word[CTRL_LAST]             = last;
    ctrl_word[CTRL_ZCLEAR]           = cfg_zclear;
    ctrl_word[CTRL_FLUSH]            = cfg_flush;
    ctrl_word[TILEY_MSB:TILEY_LSB]   = {2'b00, ty};
    ctrl_word[TILEX_MSB:TILEX_LSB]   = tx;
  end

  // Next-state and output decode; each word state holds its request until wait drops.
  always_comb begin
    next_state   = state;
    ra_vram_wr   = 1'b0;
    ra_vram_dout = '0;
    ra_busy      = (state != IDLE) && (state != DONE);
    ra_done      = (state == DONE);
    case (state)
      IDLE:   if (ra_gen_trig) next_state = SETUP;
      SETUP:  next_state = W_CTRL;
      W_CTRL: begin
        ra_vram_wr   = 1'b1;
        ra_vram_dout = ctrl_word;
        if (!ra_vram_wait) next_state = W_O;
      end
      W_O: begin
        ra_vram_wr   = 1'b1;
        ra_vram_dout = ptr_word(empty[0], tile_ol, offset[0]);
        if (!ra_vram_wait) next_state = W_OM;
      end
      W_OM: begin
        ra_vram_wr   = 1'b1;
        ra_vram_dout = ptr_word(empty[1], tile_ol, offset[1]);
        if (!ra_vram_wait) next_state = W_T;
      end
      W_T: begin
        ra_vram_wr   = 1'b1;
        ra_vram_dout = ptr_word(empty[2], tile_ol, offset[2]);
        if (!ra_vram_wait) next_state = W_TM;
      end
      W_TM: begin
        ra_vram_wr   = 1'b1;
        ra_vram_dout = ptr_word(empty[3], tile_ol, offset[3]);
        if (!ra_vram_wait) next_state = cfg_v2 ? W_PT : NEXT;
      end
      W_PT: begin
        ra_vram_wr   = 1'b1;
        ra_vram_dout = ptr_word(empty[4], tile_ol, offset[4]);
        if (!ra_vram_wait) next_state = NEXT;
      end
      NEXT:    next_state = last ? DONE : W_CTRL;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register and write address; reset aborts a run immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      state <= next_state;
      if (state == SETUP)
        addr <= REGION_BASE[ADDR_W-1:0];
      else if (ra_vram_wr && !ra_vram_wait)
        addr <= addr + ADDR_W'(4);
    end
  end

  // Config latch and tile walk; tile_ol advances by stride so no multiplier is needed.
  always_ff @(posedge clock) begin
    if (state == SETUP) begin
      cfg_v2     <= FPU_PARAM_CFG[21];
      cfg_alloc  <= TA_ALLOC_CTRL;
      cfg_xmax   <= TA_GLOB_TILE_CLIP[5:0];
      cfg_ymax   <= TA_GLOB_TILE_CLIP[19:16];
      cfg_zclear <= ra_zclear;
      cfg_flush  <= ra_flush;
      tx         <= '0;
      ty         <= '0;
      tile_ol    <= TA_OL_BASE[ADDR_W-1:0];
    end else if (state == NEXT) begin
      tile_ol <= tile_ol + ADDR_W'(stride);
      if (!last) begin
        if (tx == cfg_xmax) begin
          tx <= '0;
          ty <= ty + 4'd1;
        end else begin
          tx <= tx + 6'd1;
        end
      end
    end
  end

  assign ra_vram_addr = addr;

  assign unused_cfg = ^{FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0],
                        REGION_BASE[31:ADDR_W], TA_OL_BASE[31:ADDR_W],
                        TA_GLOB_TILE_CLIP[31:20], TA_GLOB_TILE_CLIP[15:6]};

endmodule

// File: tb/tb_ra_builder.sv
// Self-checking bench for ra_builder: a reference model fills a scoreboard of
// expected VRAM writes per run; a monitor pops and compares every completed write.
module tb_ra_builder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ra_gen_trig = 1'b0;
  logic [31:0] FPU_PARAM_CFG = '0;
  logic [31:0] REGION_BASE = '0;
  logic [31:0] TA_OL_BASE = '0;
  logic [31:0] TA_ALLOC_CTRL = '0;
  logic [31:0] TA_GLOB_TILE_CLIP = '0;
  logic        ra_zclear = 1'b0;
  logic        ra_flush = 1'b0;
  logic        ra_vram_wr;
  logic [23:0] ra_vram_addr;
  logic [31:0] ra_vram_dout;
  logic        ra_vram_wait = 1'b0;
  logic        ra_busy;
  logic        ra_done;

  always #5 clock = ~clock;

  ra_builder #(.ADDR_W(24)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .ra_gen_trig       (ra_gen_trig),
    .FPU_PARAM_CFG     (FPU_PARAM_CFG),
    .REGION_BASE       (REGION_BASE),
    .TA_OL_BASE        (TA_OL_BASE),
    .TA_ALLOC_CTRL     (TA_ALLOC_CTRL),
    .TA_GLOB_TILE_CLIP (TA_GLOB_TILE_CLIP),
    .ra_zclear         (ra_zclear),
    .ra_flush          (ra_flush),
    .ra_vram_wr        (ra_vram_wr),
    .ra_vram_addr      (ra_vram_addr),
    .ra_vram_dout      (ra_vram_dout),
    .ra_vram_wait      (ra_vram_wait),
    .ra_busy           (ra_busy),
    .ra_done           (ra_done)
  );

  typedef struct {
    logic [23:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] region;
    logic [31:0] olbase;
    logic [31:0] alloc;
    logic [31:0] clip;
    logic        v2;
    logic        zc;
    logic        fl;
    int          stall;
    int          trig_a;
    int          trig_b;   // -1 = pulse during the DONE cycle
  } case_t;

  wr_t   exp_q[$];
  wr_t   log_q[$];
  int    checks = 0;
  int    passes = 0;
  int    done_cnt = 0;
  int    stall_left = 0;
  case_t cases[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
  endtask

  function automatic wr_t log_at(input int i);
    wr_t w;
    w = '{24'h0, 32'h0};
    if (i < log_q.size()) w = log_q[i];
    return w;
  endfunction

  function automatic int lbytes(input logic [1:0] c);
    case (c)
      2'd1:    return 32;
      2'd2:    return 64;
      2'd3:    return 128;
      default: return 0;
    endcase
  endfunction

  // Reference model: expected write stream for one run.
  task automatic push_expected(input case_t c);
    int          xmax, ymax, nptr, stride, tile, off;
    logic [23:0] a, base;
    logic [31:0] ctrl, d;
    logic [1:0]  code;
    xmax = int'(c.clip[5:0]);
    ymax = int'(c.clip[19:16]);
    nptr = c.v2 ? 5 : 4;
    stride = 0;
    for (int i = 0; i < 5; i++) stride += lbytes(c.alloc[4*i +: 2]);
    a = c.region[23:0];
    for (int y = 0; y <= ymax; y++) begin
      for (int x = 0; x <= xmax; x++) begin
        tile = y * (xmax + 1) + x;
        base = 24'(c.olbase[23:0] + 24'(tile * stride));
        ctrl = 32'((y << 8) | (x << 2));
        if (x == xmax && y == ymax) ctrl = ctrl | 32'h8000_0000;
        if (c.zc) ctrl = ctrl | 32'h4000_0000;
        if (c.fl) ctrl = ctrl | 32'h1000_0000;
        exp_q.push_back('{a, ctrl});
        a = a + 24'd4;
        off = 0;
        for (int i = 0; i < nptr; i++) begin
          code = c.alloc[4*i +: 2];
          d = (code == 2'd0) ? 32'h8000_0000 : {8'h00, 24'(base + 24'(off))};
          exp_q.push_back('{a, d});
          a = a + 24'd4;
          off += lbytes(code);
        end
      end
    end
  endtask

  task automatic apply_cfg(input case_t c);
    REGION_BASE       = c.region;
    TA_OL_BASE        = c.olbase;
    TA_ALLOC_CTRL     = c.alloc;
    TA_GLOB_TILE_CLIP = c.clip;
    FPU_PARAM_CFG     = c.v2 ? 32'h0020_0000 : 32'hFFDF_FFFF;
    ra_zclear         = c.zc;
    ra_flush          = c.fl;
  endtask

  // Run one table entry: trigger, scramble inputs after latching, wait for done.
  task automatic run_case(input case_t c);
    int tiles, nptr, exp_cyc, cyc, done_at, tb_at;
    apply_cfg(c);
    exp_q.delete();
    log_q.delete();
    done_cnt = 0;
    stall_left = c.stall;
    push_expected(c);
    tiles = (int'(c.clip[5:0]) + 1) * (int'(c.clip[19:16]) + 1);
    nptr = c.v2 ? 5 : 4;
    exp_cyc = 2 + tiles * (nptr + 2) + c.stall;
    tb_at = (c.trig_b < 0) ? exp_cyc : c.trig_b;
    done_at = -1;
    cyc = 0;
    @(posedge clock);
    #1 ra_gen_trig = 1'b1;
    while (cyc < exp_cyc + 40) begin
      @(posedge clock);
      cyc++;
      #1;
      ra_gen_trig = (cyc == c.trig_a) || (cyc == tb_at);
      if (cyc == 2) begin
        REGION_BASE       = ~c.region;
        TA_OL_BASE        = ~c.olbase;
        TA_ALLOC_CTRL     = ~c.alloc;
        TA_GLOB_TILE_CLIP = ~c.clip;
        FPU_PARAM_CFG     = ~FPU_PARAM_CFG;
        ra_zclear         = ~c.zc;
        ra_flush          = ~c.fl;
      end
      @(negedge clock);
      if (ra_done && done_at < 0) done_at = cyc;
      if (done_at >= 0 && cyc >= done_at + 3 && cyc > tb_at) break;
    end
    ra_gen_trig = 1'b0;
    chk({c.name, " done cycle"}, done_at, exp_cyc);
    chk({c.name, " words left"}, exp_q.size(), 0);
    chk({c.name, " done pulses"}, done_cnt, 1);
    chk({c.name, " busy after"}, {31'b0, ra_busy}, 0);
  endtask

  // Monitor: stable request while stalled, in-order match on completion.
  always @(negedge clock) begin
    if (ra_done) done_cnt++;
    if (ra_vram_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected write addr", {8'h0, ra_vram_addr}, 32'hFFFF_FFFF);
      end else if (ra_vram_wait) begin
        chk("stalled addr", {8'h0, ra_vram_addr}, {8'h0, exp_q[0].addr});
        chk("stalled data", ra_vram_dout, exp_q[0].data);
      end else begin
        chk("write addr", {8'h0, ra_vram_addr}, {8'h0, exp_q[0].addr});
        chk("write data", ra_vram_dout, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (!ra_vram_wait) log_q.push_back('{ra_vram_addr, ra_vram_dout});
    end
  end

  // Wait generator: stalls the second word of a run for stall_left cycles.
  always @(posedge clock) begin
    #1;
    if (stall_left > 0 && ra_vram_wr && log_q.size() == 1) begin
      ra_vram_wait = 1'b1;
      stall_left--;
    end else begin
      ra_vram_wait = 1'b0;
    end
  end

  initial begin
    cases[0] = '{"one_tile", 32'h0500_1000, 32'h0010_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    cases[1] = '{"grid2x2",  32'h0500_1000, 32'h0010_0000, 32'h0000_0101, 32'h0001_0001, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    cases[2] = '{"wrap",     32'h00FF_FFF8, 32'h00FF_FF80, 32'h0003_1213, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 0, 0, 0};
    cases[3] = '{"empty3x2", 32'h0000_2000, 32'h0040_0000, 32'h0000_0000, 32'h0001_0002, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    cases[4] = '{"grid4x3",  32'h0003_0000, 32'h0020_0000, 32'h0003_2123, 32'h0002_0003, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    cases[5] = '{"stall",    32'h0500_1000, 32'h0010_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3, 0, 0};
    cases[6] = '{"retrig",   32'h0500_1000, 32'h0010_0000, 32'h0000_0101, 32'h0001_0001, 1'b1, 1'b0, 1'b0, 0, 5, -1};

    // Reset state
    #2;
    chk("reset wr",   {31'b0, ra_vram_wr}, 0);
    chk("reset addr", {8'h0, ra_vram_addr}, 0);
    chk("reset dout", ra_vram_dout, 0);
    chk("reset busy", {31'b0, ra_busy}, 0);
    chk("reset done", {31'b0, ra_done}, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_case(cases[i]);
      if (i == 0) begin
        chk("one_tile count", log_q.size(), 5);
        chk("one_tile addr0", {8'h0, log_at(0).addr}, 32'h0000_1000);
        chk("one_tile addr4", {8'h0, log_at(4).addr}, 32'h0000_1010);
        chk("one_tile ctrl",  log_at(0).data, 32'h8000_0000);
        chk("one_tile o ptr", log_at(1).data, 32'h0010_0000);
        chk("one_tile pt",    log_at(4).data, 32'h8000_0000);
      end
      if (i == 1) begin
        chk("grid2x2 count",  log_q.size(), 24);
        chk("grid2x2 e3 addr", {8'h0, log_at(18).addr}, 32'h0000_1048);
        chk("grid2x2 e3 ctrl", log_at(18).data, 32'h8000_0104);
        chk("grid2x2 e3 o",    log_at(19).data, 32'h0010_00C0);
        chk("grid2x2 e3 om",   log_at(20).data, 32'h8000_0000);
        chk("grid2x2 e3 t",    log_at(21).data, 32'h0010_00E0);
        chk("grid2x2 e3 pt",   log_at(23).data, 32'h8000_0000);
        chk("grid2x2 e0 last", {31'b0, log_at(0).data[31]}, 0);
        chk("grid2x2 e1 last", {31'b0, log_at(6).data[31]}, 0);
        chk("grid2x2 e2 last", {31'b0, log_at(12).data[31]}, 0);
      end
      if (i == 2) begin
        chk("wrap addr1", {8'h0, log_at(1).addr}, 32'h00FF_FFFC);
        chk("wrap addr2", {8'h0, log_at(2).addr}, 32'h0000_0000);
        chk("wrap addr4", {8'h0, log_at(4).addr}, 32'h0000_0008);
        chk("wrap ctrl",  log_at(0).data, 32'hD000_0000);
        chk("wrap om ptr", log_at(2).data, 32'h0000_0000);
      end
    end

    // Reset during entry 1 of a 2x2 v2 run, then a fresh run from REGION_BASE.
    apply_cfg(cases[1]);
    exp_q.delete();
    log_q.delete();
    push_expected(cases[1]);
    @(posedge clock);
    #1 ra_gen_trig = 1'b1;
    @(posedge clock);
    #1 ra_gen_trig = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("abort wr",   {31'b0, ra_vram_wr}, 0);
    chk("abort addr", {8'h0, ra_vram_addr}, 0);
    chk("abort dout", ra_vram_dout, 0);
    chk("abort busy", {31'b0, ra_busy}, 0);
    chk("abort done", {31'b0, ra_done}, 0);
    chk("abort words before reset", log_q.size(), 8);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("abort stays idle", {31'b0, ra_busy}, 0);
    run_case(cases[0]);
    chk("restart addr0", {8'h0, log_at(0).addr}, 32'h0000_1000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
